// File: rtl/deserialize_if.sv
// Serial-link bundle between the ciphertext transmitter (master) and the deserializer (slave).
// The master drives the serial bit and its framing flags; the slave returns the rebuilt word.
interface deserialize_if #(
    parameter int unsigned MSG_SIZE = 512
);
    logic                serial_in;
    logic                serial_start;
    logic                serial_end;
    logic [MSG_SIZE-1:0] ciphertext;
    logic                data_valid;
    logic                busy;
    logic                frame_err;

    modport master (
        output serial_in,
        output serial_start,
        output serial_end,
        input  ciphertext,
        input  data_valid,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  serial_in,
        input  serial_start,
        input  serial_end,
        output ciphertext,
        output data_valid,
        output busy,
        output frame_err
    );
endinterface

// File: rtl/deserialize.sv
// Rebuilds an MSB-first serial ciphertext frame into a MSG_SIZE-bit word.
// Optional framing checks are enabled by defining DESER_FRAME_CHECK_EN.
module deserialize #(
    parameter int unsigned MSG_SIZE = 512
) (
    input logic         iClk,
    input logic         iRst,
    deserialize_if.slave bus
);
    localparam int unsigned CntW = $clog2(MSG_SIZE + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MSG_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // Only MSG_SIZE-1 bits are stored; the final bit joins them on the completing edge.
    logic [MSG_SIZE-2:0] sreg_q, sreg_d;
    logic [MSG_SIZE-1:0] ct_q, ct_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [MSG_SIZE-1:0] shifted;

    assign shifted = {sreg_q, bus.serial_in};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            ct_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        ct_d    = ct_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.serial_start) begin
                    sreg_d  = shifted[MSG_SIZE-2:0];
                    cnt_d   = CntW'(1);
                    state_d = StShift;
`ifdef DESER_FRAME_CHECK_EN
                    // End on the very first bit is always premature (MSG_SIZE >= 2).
                    if (bus.serial_end) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StHold;
                    end
`endif
                end
            end
            StShift: begin
                if (!bus.serial_start) begin
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
`ifdef DESER_FRAME_CHECK_EN
                    err_d   = 1'b1;
`endif
                end else if (cnt_q == LastCnt) begin
                    sreg_d  = shifted[MSG_SIZE-2:0];
                    cnt_d   = '0;
                    state_d = StHold;
`ifdef DESER_FRAME_CHECK_EN
                    if (bus.serial_end) begin
                        ct_d    = shifted;
                        valid_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
`else
                    ct_d    = shifted;
                    valid_d = 1'b1;
`endif
                end else begin
                    sreg_d = shifted[MSG_SIZE-2:0];
                    cnt_d  = cnt_q + CntW'(1);
`ifdef DESER_FRAME_CHECK_EN
                    if (bus.serial_end) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StHold;
                    end
`endif
                end
            end
            StHold: begin
                // Transmitter keeps start high after a frame; wait for it to drop.
                if (!bus.serial_start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ciphertext = ct_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (state_q == StShift);

`ifdef DESER_FRAME_CHECK_EN
    assign bus.frame_err  = err_q;
`else
    logic unused_end;
    logic unused_err;
    assign unused_end     = bus.serial_end;
    assign unused_err     = err_q;
    assign bus.frame_err  = 1'b0;
`endif
endmodule

// File: tb/tb_deserialize.sv
// Directed bench for deserialize at MSG_SIZE=8 and MSG_SIZE=512.
// Framing-error expectations follow DESER_FRAME_CHECK_EN.
module tb_deserialize;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    logic [511:0] big;

    always #5 clk = ~clk;

    deserialize_if #(.MSG_SIZE(8))   b8 ();
    deserialize_if #(.MSG_SIZE(512)) b512 ();

    deserialize #(.MSG_SIZE(8))   dut8   (.iClk(clk), .iRst(rst), .bus(b8));
    deserialize #(.MSG_SIZE(512)) dut512 (.iClk(clk), .iRst(rst), .bus(b512));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic s, input logic d, input logic e);
        b8.serial_start = s;
        b8.serial_in    = d;
        b8.serial_end   = e;
        tick();
    endtask

    // Shift the first nbits of data; checks follow every bit but the last.
    task automatic shift8(input logic [7:0] data, input int end_at, input int nbits);
        for (int i = 1; i <= nbits; i++) begin
            drive8(1'b1, data[8-i], (i == end_at));
            if (i < nbits) begin
                chk($sformatf("busy_bit%0d", i), b8.busy, 1'b1);
                chk($sformatf("novalid_bit%0d", i), b8.data_valid, 1'b0);
            end
        end
    endtask

    initial begin
        logic exp_err;
`ifdef DESER_FRAME_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        b512.serial_start = 1'b0;
        b512.serial_in    = 1'b0;
        b512.serial_end   = 1'b0;

        // 1. Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b8.serial_in      = 1'($urandom);
            b8.serial_start   = 1'($urandom);
            b8.serial_end     = 1'($urandom);
            b512.serial_in    = 1'($urandom);
            b512.serial_start = 1'($urandom);
            b512.serial_end   = 1'($urandom);
            tick();
        end
        chk("rst_ct", b8.ciphertext, 8'h00);
        chk("rst_valid", b8.data_valid, 1'b0);
        chk("rst_busy", b8.busy, 1'b0);
        chk("rst_err", b8.frame_err, 1'b0);
        chk("rst_ct512", b512.ciphertext, 512'd0);
        b512.serial_start = 1'b0;
        b512.serial_end   = 1'b0;
        rst = 1'b0;
        drive8(1'b0, 1'b0, 1'b0);
        chk("idle_busy", b8.busy, 1'b0);

        // 2. Nominal 0xA5, then start/end held high for 5 cycles
        shift8(8'hA5, 8, 8);
        chk("a5_valid", b8.data_valid, 1'b1);
        chk("a5_ct", b8.ciphertext, 8'hA5);
        chk("a5_busy", b8.busy, 1'b0);
        chk("a5_err", b8.frame_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive8(1'b1, 1'b1, 1'b1);
            chk($sformatf("hold_valid%0d", i), b8.data_valid, 1'b0);
            chk($sformatf("hold_busy%0d", i), b8.busy, 1'b0);
        end
        chk("hold_ct", b8.ciphertext, 8'hA5);
        drive8(1'b0, 1'b0, 1'b0);

        // 3. Back-to-back 0x3C, one idle cycle, 0xC3
        shift8(8'h3C, 8, 8);
        chk("3c_valid", b8.data_valid, 1'b1);
        chk("3c_ct", b8.ciphertext, 8'h3C);
        drive8(1'b0, 1'b0, 1'b0);
        chk("gap_valid", b8.data_valid, 1'b0);
        shift8(8'hC3, 8, 8);
        chk("c3_valid", b8.data_valid, 1'b1);
        chk("c3_ct", b8.ciphertext, 8'hC3);
        drive8(1'b0, 1'b0, 1'b0);

        // 4. Abort after 5 bits of 0xFF, then 0x81
        shift8(8'hFF, 0, 5);
        chk("abort_busy5", b8.busy, 1'b1);
        drive8(1'b0, 1'b1, 1'b0);
        chk("abort_valid", b8.data_valid, 1'b0);
        chk("abort_ct", b8.ciphertext, 8'hC3);
        chk("abort_busy", b8.busy, 1'b0);
        chk("abort_err", b8.frame_err, exp_err);
        drive8(1'b0, 1'b0, 1'b0);
        chk("abort_err_once", b8.frame_err, 1'b0);
        chk("abort_novalid", b8.data_valid, 1'b0);
        shift8(8'h81, 8, 8);
        chk("81_valid", b8.data_valid, 1'b1);
        chk("81_ct", b8.ciphertext, 8'h81);
        chk("81_err", b8.frame_err, 1'b0);
        drive8(1'b0, 1'b0, 1'b0);

`ifdef DESER_FRAME_CHECK_EN
        // 5. Premature end on bit 4, then missing end on bit 8
        shift8(8'h77, 4, 4);
        chk("early_err", b8.frame_err, 1'b1);
        chk("early_valid", b8.data_valid, 1'b0);
        chk("early_busy", b8.busy, 1'b0);
        for (int i = 5; i <= 8; i++) begin
            drive8(1'b1, 1'b1, 1'b1);
            chk($sformatf("early_hold_err%0d", i), b8.frame_err, 1'b0);
            chk($sformatf("early_hold_valid%0d", i), b8.data_valid, 1'b0);
        end
        drive8(1'b0, 1'b0, 1'b0);
        shift8(8'h77, 0, 8);
        chk("noend_err", b8.frame_err, 1'b1);
        chk("noend_valid", b8.data_valid, 1'b0);
        chk("noend_ct", b8.ciphertext, 8'h81);
        drive8(1'b0, 1'b0, 1'b0);
        chk("noend_err_once", b8.frame_err, 1'b0);
`endif

        // 6. Reset at bit 3 of 0x5A, then a full 0x5A frame
        shift8(8'h5A, 8, 3);
        chk("mid_busy", b8.busy, 1'b1);
        rst = 1'b1;
        drive8(1'b1, 1'b1, 1'b0);
        chk("midrst_ct", b8.ciphertext, 8'h00);
        chk("midrst_valid", b8.data_valid, 1'b0);
        chk("midrst_busy", b8.busy, 1'b0);
        chk("midrst_err", b8.frame_err, 1'b0);
        rst = 1'b0;
        drive8(1'b0, 1'b0, 1'b0);
        chk("postrst_valid", b8.data_valid, 1'b0);
        shift8(8'h5A, 8, 8);
        chk("5a_valid", b8.data_valid, 1'b1);
        chk("5a_ct", b8.ciphertext, 8'h5A);
        drive8(1'b0, 1'b0, 1'b0);
        chk("5a_pulse_once", b8.data_valid, 1'b0);

        // 512-bit nominal frame with random data
        for (int w = 0; w < 16; w++) begin
            big[w*32 +: 32] = $urandom;
        end
        for (int i = 511; i >= 0; i--) begin
            b512.serial_start = 1'b1;
            b512.serial_in    = big[i];
            b512.serial_end   = (i == 0);
            tick();
            if (i == 256) begin
                chk("w512_busy", b512.busy, 1'b1);
                chk("w512_novalid", b512.data_valid, 1'b0);
            end
        end
        chk("w512_valid", b512.data_valid, 1'b1);
        chk("w512_ct", b512.ciphertext, big);
        chk("w512_err", b512.frame_err, 1'b0);
        tick();
        chk("w512_pulse_once", b512.data_valid, 1'b0);
        chk("w512_hold_busy", b512.busy, 1'b0);
        b512.serial_start = 1'b0;
        b512.serial_end   = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
